// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/grant and memory-control signals between the
// requesters and the shared data-memory arbiter.
interface mem_port_arbiter_if;
  logic [3:0] req;
  logic [3:0] we;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       mem_en;
  logic       mem_we;
  logic [3:0] done;
  logic       busy;

  // Arbiter side: consumes requests and produces grants and memory controls.
  modport slave (
    input  req, we,
    output gnt, sel, mem_en, mem_we, done, busy
  );

  // Requester side: produces requests and observes grants and completions.
  modport master (
    output req, we,
    input  gnt, sel, mem_en, mem_we, done, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single-port 16-bit data memory shared by
// fetch, load/store, DMA and debug. Each access holds the grant, mux select
// and memory enables for MEM_LAT cycles and pulses done in its last cycle;
// one IDLE arbitration cycle always separates consecutive accesses.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Search last+1, last+2, last+3, last (mod 4); the first set request wins.
  function automatic logic [1:0] pick_winner(input logic [3:0] req_v,
                                             input logic [1:0] last_v);
    logic [1:0] win;
    logic [1:0] cand;
    logic       found;
    win   = last_v;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_v + 2'(k);
      if (!found && req_v[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       winner_s;

  // State, grant, memory-control and latency-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      last_q   <= 2'd3;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Arbitrate in IDLE, count the fixed latency in ACCESS, release after done.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    winner_s = pick_winner(bus.req, last_q);
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d  = ACCESS;
          gnt_d    = 4'b0001 << winner_s;
          sel_d    = winner_s;
          mem_en_d = 1'b1;
          mem_we_d = bus.we[winner_s];
          last_d   = winner_s;
          cnt_d    = CNT_W'(MEM_LAT - 1);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last access cycle: done is showing now, drop everything next edge.
          state_d  = IDLE;
          gnt_d    = 4'b0000;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'b0000;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.mem_en = mem_en_q;
  assign bus.mem_we = mem_we_q;
  assign bus.busy   = (state_q == ACCESS);
  assign bus.done   = ((state_q == ACCESS) && (cnt_q == {CNT_W{1'b0}})) ? gnt_q : 4'b0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 4) share one
// request stream. A cycle-indexed model predicts every output on every
// cycle; directed sequences pin the model with hand-computed values.
module tb_mem_port_arbiter;

  localparam int LAT [3] = '{1, 2, 4};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_r = 4'b0000;
  logic [3:0] we_r  = 4'b0000;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if if1 ();
  mem_port_arbiter_if if2 ();
  mem_port_arbiter_if if4 ();

  assign if1.req = req_r;
  assign if1.we  = we_r;
  assign if2.req = req_r;
  assign if2.we  = we_r;
  assign if4.req = req_r;
  assign if4.we  = we_r;

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mem_port_arbiter #(.MEM_LAT(2), .CNT_W(4)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  mem_port_arbiter #(.MEM_LAT(4), .CNT_W(4)) u4 (.clk(clk), .reset(reset), .bus(if4.slave));

  always #5 clk = ~clk;

  logic [3:0] gnt_a [3];
  logic [1:0] sel_a [3];
  logic       en_a  [3];
  logic       mwe_a [3];
  logic [3:0] done_a[3];
  logic       busy_a[3];

  assign gnt_a[0] = if1.gnt;    assign gnt_a[1] = if2.gnt;    assign gnt_a[2] = if4.gnt;
  assign sel_a[0] = if1.sel;    assign sel_a[1] = if2.sel;    assign sel_a[2] = if4.sel;
  assign en_a[0]  = if1.mem_en; assign en_a[1]  = if2.mem_en; assign en_a[2]  = if4.mem_en;
  assign mwe_a[0] = if1.mem_we; assign mwe_a[1] = if2.mem_we; assign mwe_a[2] = if4.mem_we;
  assign done_a[0] = if1.done;  assign done_a[1] = if2.done;  assign done_a[2] = if4.done;
  assign busy_a[0] = if1.busy;  assign busy_a[1] = if2.busy;  assign busy_a[2] = if4.busy;

  // Reference model: an access occupies cycles [t0, t0+LAT); cyc counts clock edges.
  longint cyc = 0;
  bit     act_m  [3];
  longint t0_m   [3];
  int     own_m  [3];
  bit     wr_m   [3];
  int     last_m [3];
  int     sel_m  [3];

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic check4(input string name, input int inst,
                        input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lat%0d got %b expected %b at %0t", name, LAT[inst], got, exp, $time);
    end
  endtask

  // Advance the model on each edge; asynchronous reset clears it at once.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        act_m[i]  <= 1'b0;
        last_m[i] <= 3;
        sel_m[i]  <= 0;
        own_m[i]  <= 0;
        wr_m[i]   <= 1'b0;
        t0_m[i]   <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (act_m[i]) begin
          if (cyc + 1 >= t0_m[i] + LAT[i]) act_m[i] <= 1'b0;
        end else if (req_r != 4'b0000) begin
          act_m[i]  <= 1'b1;
          t0_m[i]   <= cyc + 1;
          own_m[i]  <= pick(req_r, last_m[i]);
          sel_m[i]  <= pick(req_r, last_m[i]);
          last_m[i] <= pick(req_r, last_m[i]);
          wr_m[i]   <= we_r[pick(req_r, last_m[i])];
        end
      end
    end
  end

  // Compare every output of every instance against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [3:0] eg;
      logic [3:0] ed;
      eg = act_m[i] ? (4'b0001 << own_m[i]) : 4'b0000;
      ed = (act_m[i] && (cyc == t0_m[i] + LAT[i] - 1)) ? eg : 4'b0000;
      check4("gnt",    i, gnt_a[i], eg);
      check4("sel",    i, {2'b00, sel_a[i]}, 4'(sel_m[i]));
      check4("mem_en", i, {3'b000, en_a[i]}, {3'b000, act_m[i]});
      check4("mem_we", i, {3'b000, mwe_a[i]}, {3'b000, act_m[i] & wr_m[i]});
      check4("done",   i, done_a[i], ed);
      check4("busy",   i, {3'b000, busy_a[i]}, {3'b000, act_m[i]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Quiet after reset.
    repeat (5) begin
      tick();
      check4("idle_gnt", 1, if2.gnt, 4'b0000);
      check4("idle_busy", 1, {3'b000, if2.busy}, 4'b0000);
    end

    // Single write from requester 2.
    req_r = 4'b0100; we_r = 4'b0100;
    tick();
    check4("wr_gnt", 1, if2.gnt, 4'b0100);
    check4("wr_sel", 1, {2'b00, if2.sel}, 4'd2);
    check4("wr_en", 1, {3'b000, if2.mem_en}, 4'd1);
    check4("wr_we", 1, {3'b000, if2.mem_we}, 4'd1);
    check4("wr_done1", 1, if2.done, 4'b0000);
    check4("lat1_done", 0, if1.done, 4'b0100);
    check4("lat4_done1", 2, if4.done, 4'b0000);
    req_r = 4'b0000; we_r = 4'b0000;
    tick();
    check4("wr_gnt2", 1, if2.gnt, 4'b0100);
    check4("wr_done2", 1, if2.done, 4'b0100);
    check4("lat1_rel", 0, if1.gnt, 4'b0000);
    tick();
    check4("wr_rel", 1, if2.gnt, 4'b0000);
    check4("wr_en_rel", 1, {3'b000, if2.mem_en}, 4'd0);
    check4("wr_sel_hold", 1, {2'b00, if2.sel}, 4'd2);
    repeat (4) tick();

    // Everyone requesting: grants 0,1,2,3,0,1, two cycles each, one gap.
    do_reset();
    req_r = 4'b1111;
    for (int c = 0; c < 18; c++) begin
      logic [3:0] eg;
      tick();
      eg = (c % 3 == 2) ? 4'b0000 : (4'b0001 << ((c / 3) % 4));
      check4("rr_gnt", 1, if2.gnt, eg);
      check4("rr_done", 1, if2.done, (c % 3 == 1) ? eg : 4'b0000);
    end

    // Fairness: after requester 1, req=1010 goes to 3 then 1.
    req_r = 4'b0000;
    do_reset();
    req_r = 4'b0010;
    tick();
    check4("fair_g1", 1, if2.gnt, 4'b0010);
    req_r = 4'b1010;
    tick();
    tick();
    check4("fair_gap", 1, if2.gnt, 4'b0000);
    tick();
    check4("fair_g3", 1, if2.gnt, 4'b1000);
    repeat (3) tick();
    check4("fair_g1b", 1, if2.gnt, 4'b0010);

    // Drop mid-access and late request.
    req_r = 4'b0000;
    do_reset();
    req_r = 4'b0001;
    tick();
    check4("drop_g0", 1, if2.gnt, 4'b0001);
    req_r = 4'b0100;
    tick();
    check4("drop_done", 1, if2.done, 4'b0001);
    tick();
    check4("late_gap", 1, if2.gnt, 4'b0000);
    tick();
    check4("late_g2", 1, if2.gnt, 4'b0100);

    // Reset in the second ACCESS cycle of the MEM_LAT=4 instance.
    req_r = 4'b0000;
    do_reset();
    req_r = 4'b0010;
    tick();
    tick();
    check4("mid_sel", 2, {2'b00, if4.sel}, 4'd1);
    #1 reset = 1'b1;
    #1;
    check4("rst_gnt", 2, if4.gnt, 4'b0000);
    check4("rst_sel", 2, {2'b00, if4.sel}, 4'd0);
    check4("rst_en", 2, {3'b000, if4.mem_en}, 4'd0);
    check4("rst_we", 2, {3'b000, if4.mem_we}, 4'd0);
    check4("rst_done", 2, if4.done, 4'b0000);
    check4("rst_busy", 2, {3'b000, if4.busy}, 4'd0);
    tick();
    tick();
    req_r = 4'b1001;
    reset = 1'b0;
    tick();
    check4("rst_first", 2, if4.gnt, 4'b0001);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      req_r = 4'($urandom);
      we_r  = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
